// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory arbiter: FSM states and owner indices.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: one-hot grant plus owner index.
// On contention the master that did not own the previous access wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] gnt,
  output logic       owner
);

  // Grant selection from request vector and previous owner
  always_comb begin
    gnt   = 2'b00;
    owner = OWN_M0;
    case (req)
      2'b01: begin
        gnt   = 2'b01;
        owner = OWN_M0;
      end
      2'b10: begin
        gnt   = 2'b10;
        owner = OWN_M1;
      end
      2'b11: begin
        if (last_owner == OWN_M0) begin
          gnt   = 2'b10;
          owner = OWN_M1;
        end else begin
          gnt   = 2'b01;
          owner = OWN_M0;
        end
      end
      default: begin
        gnt   = 2'b00;
        owner = OWN_M0;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for two masters, one access in flight.
// Optional build macro MEM_ARB_LOCK_EN adds m0_lock/m1_lock for locked sequences.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic          m0_lock,
  input  logic          m1_lock,
`endif
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t          state_r;
  state_t          next_state_s;
  logic            owner_r;
  logic            last_owner_r;
  logic            we_r;
  logic [AW-1:0]   addr_r;
  logic [DW-1:0]   wdata_r;
  logic [DW-1:0]   rdata_r;
  logic [CW-1:0]   cnt_r;
  logic [1:0]      req_s;
  logic [1:0]      arb_req_s;
  logic [1:0]      gnt_s;
  logic            pick_s;
  logic            accept_s;
  logic            cnt_done_s;

  assign req_s      = {m1_req, m0_req};
  assign accept_s   = |gnt_s;
  assign cnt_done_s = (cnt_r == CNT_ZERO);

`ifdef MEM_ARB_LOCK_EN
  logic       lock_r;
  logic       lock_hold_s;
  logic [1:0] lock_in_s;

  assign lock_in_s   = {m1_lock, m0_lock};
  // The lock survives only while its owner keeps asking with lock held.
  assign lock_hold_s = lock_r & req_s[owner_r] & lock_in_s[owner_r];
`endif

  // Requests are visible to the picker only in IDLE and out of reset
  always_comb begin
    arb_req_s = 2'b00;
    if (rst && (state_r == IDLE)) begin
`ifdef MEM_ARB_LOCK_EN
      if (lock_hold_s) begin
        arb_req_s = (owner_r == OWN_M1) ? 2'b10 : 2'b01;
      end else begin
        arb_req_s = req_s;
      end
`else
      arb_req_s = req_s;
`endif
    end else begin
      arb_req_s = 2'b00;
    end
  end

  rr_arb2 u_rr_arb2 (
    .req        (arb_req_s),
    .last_owner (last_owner_r),
    .gnt        (gnt_s),
    .owner      (pick_s)
  );

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = ACCESS;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCESS: next_state_s = WAIT;
      WAIT: begin
        if (cnt_done_s) begin
          next_state_s = RESP;
        end else begin
          next_state_s = WAIT;
        end
      end
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Request latch, latency counter and read-data capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_r      <= OWN_M0;
      last_owner_r <= OWN_M1;
      we_r         <= 1'b0;
      addr_r       <= {AW{1'b0}};
      wdata_r      <= {DW{1'b0}};
      rdata_r      <= {DW{1'b0}};
      cnt_r        <= CNT_ZERO;
    end else begin
      if (accept_s) begin
        owner_r      <= pick_s;
        last_owner_r <= pick_s;
        we_r         <= (pick_s == OWN_M1) ? m1_we    : m0_we;
        addr_r       <= (pick_s == OWN_M1) ? m1_addr  : m0_addr;
        wdata_r      <= (pick_s == OWN_M1) ? m1_wdata : m0_wdata;
      end
      if (state_r == ACCESS) begin
        cnt_r <= CNT_LOAD;
      end else if ((state_r == WAIT) && !cnt_done_s) begin
        cnt_r <= cnt_r - CNT_ONE;
      end
      // Writes complete with a zero payload so stale read data never leaks.
      if ((state_r == WAIT) && cnt_done_s) begin
        rdata_r <= we_r ? {DW{1'b0}} : mem_rdata;
      end
    end
  end

`ifdef MEM_ARB_LOCK_EN
  // Lock capture at completion, release on the following IDLE evaluation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_r <= 1'b0;
    end else if (state_r == RESP) begin
      lock_r <= lock_in_s[owner_r];
    end else if (state_r == IDLE) begin
      lock_r <= lock_hold_s;
    end
  end
`endif

  assign m0_gnt    = gnt_s[0];
  assign m1_gnt    = gnt_s[1];
  assign m0_rvalid = (state_r == RESP) && (owner_r == OWN_M0);
  assign m1_rvalid = (state_r == RESP) && (owner_r == OWN_M1);
  assign m0_rdata  = rdata_r;
  assign m1_rdata  = rdata_r;
  assign mem_en    = (state_r == ACCESS);
  assign mem_we    = (state_r == ACCESS) && we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model, random
// and directed traffic on a MEM_LAT=3 instance plus a MEM_LAT=1 contention instance.
module tb_mem_arbiter;

  localparam int LAT = 3;

  logic        clk, rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_LOCK_EN
  logic        m0_lock, m1_lock;
`endif

  logic        d1_m0_gnt, d1_m0_rvalid, d1_m1_gnt, d1_m1_rvalid;
  logic [31:0] d1_m0_rdata, d1_m1_rdata;
  logic        d1_mem_en, d1_mem_we;
  logic [31:0] d1_mem_addr, d1_mem_wdata;

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
`ifdef MEM_ARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .m0_req(1'b1), .m0_we(1'b0), .m0_addr(32'h0), .m0_wdata(32'h0),
    .m0_gnt(d1_m0_gnt), .m0_rvalid(d1_m0_rvalid), .m0_rdata(d1_m0_rdata),
    .m1_req(1'b1), .m1_we(1'b0), .m1_addr(32'h0), .m1_wdata(32'h0),
    .m1_gnt(d1_m1_gnt), .m1_rvalid(d1_m1_rvalid), .m1_rdata(d1_m1_rdata),
`ifdef MEM_ARB_LOCK_EN
    .m0_lock(1'b0), .m1_lock(1'b0),
`endif
    .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr),
    .mem_wdata(d1_mem_wdata), .mem_rdata(32'hDEADBEEF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;

  // Master-side pending requests (held until granted)
  bit          pend [2];
  logic        we_q [2];
  logic [31:0] addr_q [2];
  logic [31:0] wdata_q [2];
  bit          lock_in [2];

  // Reference model: transaction in flight, arbitration history, memory contents
  logic [31:0] mem_arr [256];
  bit          cur_valid;
  int          cur_g;
  bit          cur_own;
  bit          cur_we;
  logic [31:0] exp_rd;
  logic [31:0] lat_addr, lat_wdata;
  bit          last_owner;
  int          next_free;
  bit          locked;
  bit          lock_own;
  logic [1:0]  seen_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic new_req(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
    pend[i]    = 1'b1;
    we_q[i]    = we;
    addr_q[i]  = a;
    wdata_q[i] = d;
  endtask

  task automatic model_reset();
    cur_valid  = 1'b0;
    last_owner = 1'b1;
    lat_addr   = 32'h0;
    lat_wdata  = 32'h0;
    next_free  = 0;
    locked     = 1'b0;
    lock_own   = 1'b0;
  endtask

  // One clock cycle: drive inputs, predict, check at negedge, advance the model
  task automatic do_cycle();
    logic [1:0] rq, eg;
    bit win, acc, resp;
    int k, b;
    m0_req = pend[0]; m0_we = we_q[0]; m0_addr = addr_q[0]; m0_wdata = wdata_q[0];
    m1_req = pend[1]; m1_we = we_q[1]; m1_addr = addr_q[1]; m1_wdata = wdata_q[1];
`ifdef MEM_ARB_LOCK_EN
    m0_lock = lock_in[0]; m1_lock = lock_in[1];
`endif
    if (cur_valid && !cur_we && (cyc == cur_g + 1 + LAT)) mem_rdata = exp_rd;
    else mem_rdata = $urandom;

    eg  = 2'b00;
    win = 1'b0;
    if (rst && (cyc >= next_free)) begin
      rq = {pend[1], pend[0]};
      if (locked) begin
        if (pend[lock_own] && lock_in[lock_own]) rq = lock_own ? 2'b10 : 2'b01;
        else locked = 1'b0;
      end
      if (rq == 2'b11) win = ~last_owner;
      else win = rq[1];
      if (rq != 2'b00) eg[win] = 1'b1;
    end
    acc  = cur_valid && (cyc == cur_g + 1);
    resp = cur_valid && (cyc == cur_g + LAT + 2);

    @(negedge clk);
    seen_gnt = {m1_gnt, m0_gnt};
    chk("m0_gnt", m0_gnt, eg[0]);
    chk("m1_gnt", m1_gnt, eg[1]);
    chk("mem_en", mem_en, acc);
    chk("mem_we", mem_we, acc && cur_we);
    chk("mem_addr", mem_addr, lat_addr);
    chk("mem_wdata", mem_wdata, lat_wdata);
    chk("m0_rvalid", m0_rvalid, resp && !cur_own);
    chk("m1_rvalid", m1_rvalid, resp && cur_own);
    if (resp) chk(cur_own ? "m1_rdata" : "m0_rdata", cur_own ? m1_rdata : m0_rdata, exp_rd);

    if (cyc >= 0 && cyc < 40) begin
      k = cyc % 4;
      b = (cyc / 4) % 2;
      chk("d1_m0_gnt", d1_m0_gnt, (k == 0) && (b == 0));
      chk("d1_m1_gnt", d1_m1_gnt, (k == 0) && (b == 1));
      chk("d1_mem_en", d1_mem_en, k == 1);
      chk("d1_m0_rvalid", d1_m0_rvalid, (k == 3) && (b == 0));
      chk("d1_m1_rvalid", d1_m1_rvalid, (k == 3) && (b == 1));
      chk("d1_mem_side", {d1_mem_we, d1_mem_addr[15:0], d1_mem_wdata[14:0]}, 32'h0);
      if (k == 3) chk("d1_rdata", b ? d1_m1_rdata : d1_m0_rdata, 32'hDEADBEEF);
    end

    if (resp) begin
      locked    = lock_in[cur_own];
      lock_own  = cur_own;
      cur_valid = 1'b0;
    end
    if (eg != 2'b00) begin
      cur_valid  = 1'b1;
      cur_g      = cyc;
      cur_own    = win;
      cur_we     = we_q[win];
      lat_addr   = addr_q[win];
      lat_wdata  = wdata_q[win];
      last_owner = win;
      next_free  = cyc + LAT + 3;
      if (we_q[win]) begin
        mem_arr[addr_q[win][7:0]] = wdata_q[win];
        exp_rd = 32'h0;
      end else begin
        exp_rd = mem_arr[addr_q[win][7:0]];
      end
      pend[win] = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
`ifdef MEM_ARB_LOCK_EN
    m0_lock = 1'b0; m1_lock = 1'b0;
`endif
    mem_rdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; we_q[i] = 1'b0; addr_q[i] = 32'h0; wdata_q[i] = 32'h0; lock_in[i] = 1'b0;
    end
    for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;
    mem_arr[8'h10] = 32'hDEADBEEF;
    exp_rd = 32'h0;
    cur_g = 0; cur_own = 1'b0; cur_we = 1'b0;
    model_reset();
    cyc = -3;
    #1;

    // Reset: no grants even with requests pending, datapath cleared
    new_req(1, 1'b0, 32'h0000_0004, 32'h0);
    repeat (3) do_cycle();
    chk("reset_m0_rdata", m0_rdata, 32'h0);
    chk("reset_m1_rdata", m1_rdata, 32'h0);
    pend[1] = 1'b0;
    rst = 1'b1;

    // m0 read of 0x10, memory returns 0xDEADBEEF
    new_req(0, 1'b0, 32'h0000_0010, 32'h0);
    repeat (8) do_cycle();
    chk("dir_read_rdata_hold", m0_rdata, 32'hDEADBEEF);

    // m1 write 0x12345678 to 0x20
    new_req(1, 1'b1, 32'h0000_0020, 32'h1234_5678);
    repeat (8) do_cycle();

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) == 0))
          new_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
`ifdef MEM_ARB_LOCK_EN
        lock_in[i] = ($urandom_range(0, 3) == 0);
`endif
      end
      do_cycle();
    end
    lock_in[0] = 1'b0;
    lock_in[1] = 1'b0;

    // Asynchronous reset during the ACCESS cycle of an m1 write
    pend[0] = 1'b0;
    new_req(1, 1'b1, 32'h0000_0044, 32'hCAFE_F00D);
    for (int n = 0; n < 40; n++) begin
      if (cur_valid && cur_own && (cyc == cur_g + 1)) break;
      do_cycle();
    end
    chk("reach_access", {31'h0, cur_valid && cur_own && (cyc == cur_g + 1)}, 32'h1);
    chk("access_mem_we", mem_we, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_mem_we", mem_we, 1'b0);
    chk("async_rst_mem_en", mem_en, 1'b0);
    chk("async_rst_rdata", m1_rdata, 32'h0);
    model_reset();
    pend[1] = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    new_req(0, 1'b0, 32'h0000_0010, 32'h0);
    repeat (2) do_cycle();
    rst = 1'b1;
    repeat (8) do_cycle();

    // Sustained contention from both masters
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i]) new_req(i, 1'b0, $urandom, 32'h0);
      do_cycle();
    end

`ifdef MEM_ARB_LOCK_EN
    // m0 locked reads while m1 keeps requesting; m1 must win once lock drops
    lock_in[0] = 1'b1;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i]) new_req(i, 1'b0, $urandom, 32'h0);
      do_cycle();
    end
    lock_in[0] = 1'b0;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i]) new_req(i, 1'b0, $urandom, 32'h0);
      do_cycle();
      if (seen_gnt != 2'b00) begin
        chk("lock_release_gnt", {30'h0, seen_gnt}, 32'h2);
        break;
      end
      if (n == 19) chk("lock_release_timeout", 32'h0, 32'h1);
    end
`endif

    pend[0] = 1'b0;
    pend[1] = 1'b0;
    repeat (8) do_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
